// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline status into the controller, stall/flush
// controls and performance counters back out to the pipeline.
interface hazard_if #(
  parameter int unsigned CNT_W = 32
);
  // Pipeline status
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             IF_ID_uses_rs1;
  logic             IF_ID_uses_rs2;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_memread;
  logic             EX_MEM_branch_taken;
  logic             EX_MEM_memaccess;
  logic             dmem_ready;

  // Pipeline controls
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             id_ex_write_en;
  logic             ex_mem_write_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_bubble;
  logic             mem_timeout;

  // Performance counters
  logic [CNT_W-1:0] loaduse_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  // Pipeline side: drives status, consumes controls
  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
           ID_EX_rd, ID_EX_memread, EX_MEM_branch_taken,
           EX_MEM_memaccess, dmem_ready,
    input  pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           mem_timeout, loaduse_cnt, flush_cnt, memwait_cnt
  );

  // Controller side
  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
           ID_EX_rd, ID_EX_memread, EX_MEM_branch_taken,
           EX_MEM_memaccess, dmem_ready,
    output pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           mem_timeout, loaduse_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles,
// taken-branch flushes and data-memory freeze with a timeout watchdog.
// Controls are Mealy-decoded from the current state and inputs.
// Optional macro HAZARD_PERF_CNT_EN enables saturating performance counters;
// without it the counter ports are tied to zero.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hif
);

  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic freeze_c;
  logic flush_c;
  logic loaduse_c;
  logic dep_hit_c;
  logic loaduse_cond_c;

  // Load-use dependency between the EX load and the ID consumer
  always_comb begin
    dep_hit_c = 1'b0;
    if (hif.IF_ID_uses_rs1 && (hif.ID_EX_rd == hif.IF_ID_rs1)) dep_hit_c = 1'b1;
    if (hif.IF_ID_uses_rs2 && (hif.ID_EX_rd == hif.IF_ID_rs2)) dep_hit_c = 1'b1;
    loaduse_cond_c = hif.ID_EX_memread && (hif.ID_EX_rd != 5'd0) && dep_hit_c;
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic and hazard action selection
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    freeze_c  = 1'b0;
    flush_c   = 1'b0;
    loaduse_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hif.EX_MEM_memaccess && !hif.dmem_ready) begin
          freeze_c = 1'b1;
          state_d  = MEM_WAIT;
          wcnt_d   = WCNT_W'(1);
        end else if (hif.EX_MEM_branch_taken) begin
          flush_c = 1'b1;
        end else if (loaduse_cond_c) begin
          loaduse_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hif.dmem_ready) begin
          freeze_c = 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (wcnt_q == WCNT_W'(TIMEOUT_CYCLES))) begin
            state_d = ERROR;
          end else if (wcnt_q != '1) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else begin
          // Release cycle behaves as RUN with the freeze condition cleared
          state_d = RUN;
          wcnt_d  = '0;
          if (hif.EX_MEM_branch_taken) begin
            flush_c = 1'b1;
          end else if (loaduse_cond_c) begin
            loaduse_c = 1'b1;
          end
        end
      end
      ERROR: begin
        freeze_c = 1'b1;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Control decode; everything held inactive while in reset
  always_comb begin
    hif.pc_write_en     = 1'b1;
    hif.if_id_write_en  = 1'b1;
    hif.id_ex_write_en  = 1'b1;
    hif.ex_mem_write_en = 1'b1;
    hif.if_id_flush     = 1'b0;
    hif.id_ex_flush     = 1'b0;
    hif.ex_mem_flush    = 1'b0;
    hif.mem_wb_bubble   = 1'b0;
    hif.mem_timeout     = 1'b0;
    if (!rst_n) begin
      hif.pc_write_en     = 1'b0;
      hif.if_id_write_en  = 1'b0;
      hif.id_ex_write_en  = 1'b0;
      hif.ex_mem_write_en = 1'b0;
    end else begin
      hif.mem_timeout = (state_q == ERROR);
      if (freeze_c) begin
        hif.pc_write_en     = 1'b0;
        hif.if_id_write_en  = 1'b0;
        hif.id_ex_write_en  = 1'b0;
        hif.ex_mem_write_en = 1'b0;
        hif.mem_wb_bubble   = 1'b1;
      end else if (flush_c) begin
        hif.if_id_flush  = 1'b1;
        hif.id_ex_flush  = 1'b1;
        hif.ex_mem_flush = 1'b1;
      end else if (loaduse_c) begin
        hif.pc_write_en    = 1'b0;
        hif.if_id_write_en = 1'b0;
        hif.id_ex_flush    = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  // Saturating event counters
  always_comb begin
    loaduse_cnt_d = loaduse_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (loaduse_c && (loaduse_cnt_q != '1)) loaduse_cnt_d = loaduse_cnt_q + CNT_W'(1);
    if (flush_c   && (flush_cnt_q   != '1)) flush_cnt_d   = flush_cnt_q   + CNT_W'(1);
    if (freeze_c  && (memwait_cnt_q != '1)) memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaduse_cnt_q <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      loaduse_cnt_q <= loaduse_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign hif.loaduse_cnt = loaduse_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;
  assign hif.memwait_cnt = memwait_cnt_q;
`else
  assign hif.loaduse_cnt = '0;
  assign hif.flush_cnt   = '0;
  assign hif.memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (watchdog configured to 4 cycles).
module tb_hazard_stall_ctrl;

  localparam int unsigned CNT_W = 32;

  // Control vector: {pc_we, if_id_we, id_ex_we, ex_mem_we, if_fl, id_fl, ex_fl, bubble}
  localparam logic [7:0] C_RST    = 8'b0000_0000;
  localparam logic [7:0] C_IDLE   = 8'b1111_0000;
  localparam logic [7:0] C_FREEZE = 8'b0000_0001;
  localparam logic [7:0] C_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] C_LU     = 8'b0011_0100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_if #(.CNT_W(CNT_W)) hif ();

  hazard_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ctl;
  assign ctl = {hif.pc_write_en, hif.if_id_write_en, hif.id_ex_write_en, hif.ex_mem_write_en,
                hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.mem_wb_bubble};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cexp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  // One clock: through the active edge, back to the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    hif.IF_ID_rs1           = 5'd0;
    hif.IF_ID_rs2           = 5'd0;
    hif.IF_ID_uses_rs1      = 1'b0;
    hif.IF_ID_uses_rs2      = 1'b0;
    hif.ID_EX_rd            = 5'd0;
    hif.ID_EX_memread       = 1'b0;
    hif.EX_MEM_branch_taken = 1'b0;
    hif.EX_MEM_memaccess    = 1'b0;
    hif.dmem_ready          = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic uses2);
    hif.ID_EX_memread  = 1'b1;
    hif.ID_EX_rd       = rd;
    hif.IF_ID_rs2      = 5'd5;
    hif.IF_ID_uses_rs2 = uses2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_in();

    // Reset state
    @(negedge clk); #1;
    chk("rst_ctl", 64'(ctl), 64'(C_RST));
    chk("rst_timeout", 64'(hif.mem_timeout), 64'd0);
    chk("rst_lu_cnt", 64'(hif.loaduse_cnt), 64'd0);
    chk("rst_mw_cnt", 64'(hif.memwait_cnt), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 64'(ctl), 64'(C_IDLE));
    cyc();

    // Load-use on rs2: one bubble
    set_lu(5'd5, 1'b1); #1;
    chk("lu_ctl", 64'(ctl), 64'(C_LU));
    cyc();
    hif.ID_EX_memread = 1'b0; #1;
    chk("lu_after_ctl", 64'(ctl), 64'(C_IDLE));
    chk("lu_cnt1", 64'(hif.loaduse_cnt), cexp(1));

    // rd == x0: no stall
    set_lu(5'd0, 1'b1); #1;
    chk("lu_x0_ctl", 64'(ctl), 64'(C_IDLE));
    cyc();
    // rs2 not read: no stall
    set_lu(5'd5, 1'b0); #1;
    chk("lu_nouse_ctl", 64'(ctl), 64'(C_IDLE));
    cyc();
    // rs1 dependency
    clear_in();
    hif.ID_EX_memread  = 1'b1;
    hif.ID_EX_rd       = 5'd9;
    hif.IF_ID_rs1      = 5'd9;
    hif.IF_ID_uses_rs1 = 1'b1; #1;
    chk("lu_rs1_ctl", 64'(ctl), 64'(C_LU));
    cyc();
    clear_in(); #1;
    chk("lu_cnt2", 64'(hif.loaduse_cnt), cexp(2));

    // Branch beats load-use
    set_lu(5'd5, 1'b1);
    hif.EX_MEM_branch_taken = 1'b1; #1;
    chk("br_lu_ctl", 64'(ctl), 64'(C_FLUSH));
    cyc();
    clear_in(); #1;
    chk("br_lu_cnt", 64'(hif.loaduse_cnt), cexp(2));
    chk("br_fl_cnt", 64'(hif.flush_cnt), cexp(1));

    // Single-cycle access: no stall
    hif.EX_MEM_memaccess = 1'b1;
    hif.dmem_ready       = 1'b1; #1;
    chk("mem1_ctl", 64'(ctl), 64'(C_IDLE));
    cyc();

    // 3 frozen cycles with a held branch, released with the flush
    hif.dmem_ready          = 1'b0;
    hif.EX_MEM_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frz%0d", i), 64'(ctl), 64'(C_FREEZE));
      cyc();
    end
    hif.dmem_ready = 1'b1; #1;
    chk("mw_rel_ctl", 64'(ctl), 64'(C_FLUSH));
    cyc();
    clear_in(); #1;
    chk("mw_cnt3", 64'(hif.memwait_cnt), cexp(3));
    chk("mw_fl_cnt", 64'(hif.flush_cnt), cexp(2));
    chk("mw_idle_ctl", 64'(ctl), 64'(C_IDLE));

    // Watchdog: error in the 6th cycle after freeze entry
    hif.EX_MEM_memaccess = 1'b1;
    hif.dmem_ready       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("to_ctl%0d", i), 64'(ctl), 64'(C_FREEZE));
      chk($sformatf("to_flag%0d", i), 64'(hif.mem_timeout), (i == 5) ? 64'd1 : 64'd0);
      cyc();
    end
    // Sticky even when memory answers
    hif.dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("to_hold_ctl%0d", i), 64'(ctl), 64'(C_FREEZE));
      chk($sformatf("to_hold_flag%0d", i), 64'(hif.mem_timeout), 64'd1);
      cyc();
    end
    chk("to_mw_cnt", 64'(hif.memwait_cnt), cexp(11));

    // Reset pulse clears error and counters, returns to RUN
    rst_n = 1'b0; #1;
    chk("rp_ctl", 64'(ctl), 64'(C_RST));
    chk("rp_flag", 64'(hif.mem_timeout), 64'd0);
    chk("rp_mw_cnt", 64'(hif.memwait_cnt), 64'd0);
    cyc();
    rst_n = 1'b1; #1;
    chk("rp_run_ctl", 64'(ctl), 64'(C_IDLE));
    chk("rp_run_flag", 64'(hif.mem_timeout), 64'd0);
    cyc();
    clear_in(); #1;
    chk("rp_idle_ctl", 64'(ctl), 64'(C_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog for the bench itself
  initial begin
    #100000;
    $display("FAIL bench_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

- Pipeline hazard controller for the 5-stage RISC-V core.
- Handles the hazards operand forwarding cannot resolve:
  - load-use dependencies, by inserting a bubble;
  - taken branches resolved in MEM, by flushing the wrong-path stages;
  - multi-cycle data-memory accesses, by freezing the pipeline with a timeout watchdog.
- Drives the stage-register write enables and flushes, and the PC write enable.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum MEM_WAIT cycles before the error state; 0 disables the watchdog.
- CNT_W, 32: width of the performance counters.

Ports. Clock is `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_rs1, IF_ID_rs2  in  5  source registers of the instruction in ID
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ID_EX_rd  in  5  destination of the instruction in EX
- ID_EX_memread  in  1  EX instruction is a load
- EX_MEM_branch_taken  in  1  branch/jump resolved taken in MEM
- EX_MEM_memaccess  in  1  MEM instruction is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1  stage-register write enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  zero the stage-register control fields
- mem_wb_bubble  out  1  write a bubble into MEM/WB
- mem_timeout  out  1  sticky error flag
- loaduse_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters

## Operation
FSM states:
- RUN (reset state)
- MEM_WAIT
- ERROR

Wait counter `wcnt` has width clog2(TIMEOUT_CYCLES+1).

Outputs are Mealy: they decode the current state and current inputs. Default drive: all write enables 1, all flushes and `mem_wb_bubble` 0.

Conditions:
- Freeze condition F = EX_MEM_memaccess && !dmem_ready.
- Load-use condition L = ID_EX_memread && ID_EX_rd != 0 && ((IF_ID_uses_rs1 && ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && ID_EX_rd == IF_ID_rs2)).

Priority in RUN: freeze > flush > load-use.
- **Freeze** (F): all write enables 0, `mem_wb_bubble`=1. Next state MEM_WAIT, `wcnt`<=1.
- **Flush** (!F && EX_MEM_branch_taken): `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1, all write enables 1.
- **Load-use** (!F && !branch && L): `pc_write_en`=0, `if_id_write_en`=0, `id_ex_flush`=1. This gives exactly one bubble; the following cycle sees `ID_EX_memread`=0.

MEM_WAIT:
- While !dmem_ready: freeze outputs held; `wcnt` increments.
- If TIMEOUT_CYCLES != 0 and `wcnt` == TIMEOUT_CYCLES with !dmem_ready: next state ERROR.
- On dmem_ready: next state RUN, `wcnt`<=0. That same cycle's outputs are evaluated as RUN with F=0, so a held branch flush or load-use takes effect then.

ERROR:
- Freeze outputs held permanently; `mem_timeout`=1.
- Exit only via reset.

## Timing
- Reset: while `rst_n`=0, all write enables 0, all flushes and `mem_wb_bubble` 0, `mem_timeout` 0.
- Reset also clears the state to RUN and clears `wcnt` and all counters.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN on release; there is no pending-freeze memory.
- Load-use stall: 1 cycle. Branch flush: 1 cycle, same cycle as `EX_MEM_branch_taken`.
- Memory freeze: asserted the same cycle F is seen. Released the cycle `dmem_ready`=1. A 1-cycle access (`dmem_ready` already high) causes no stall.
- Flush and load-use are suppressed while frozen. Inputs are held by the frozen stage registers and re-evaluated on release.
- `mem_timeout` asserts in the first ERROR cycle, i.e. TIMEOUT_CYCLES+1 cycles after freeze entry.

## Configuration
Macro `HAZARD_PERF_CNT_EN`.
- Defined: counters are active and saturate at all-ones.
  - `loaduse_cnt` increments per load-use bubble.
  - `flush_cnt` increments per flush cycle.
  - `memwait_cnt` increments per frozen cycle, MEM_WAIT and ERROR included.
- Undefined: counter logic is removed; the counter ports remain and are driven 0.

## Test plan
- Load-use: `ID_EX_memread`=1, `ID_EX_rd`=5, `IF_ID_rs2`=5, `IF_ID_uses_rs2`=1 -> one cycle of `pc_write_en`=0, `if_id_write_en`=0, `id_ex_flush`=1; `loaduse_cnt`=1.
- Same load-use stimulus but `ID_EX_rd`=0, or `IF_ID_uses_rs2`=0 -> no stall.
- Load-use together with `EX_MEM_branch_taken`=1 -> flush only: three flushes, `pc_write_en`=1, `loaduse_cnt` unchanged.
- `EX_MEM_memaccess`=1, `dmem_ready` low for 3 cycles then high -> 3 frozen cycles with `mem_wb_bubble`=1, release on the 4th; `memwait_cnt`=3.
- TIMEOUT_CYCLES=4, `dmem_ready` held low -> `mem_timeout`=1 at cycle 5 and stays; `rst_n` pulse clears it and returns to RUN.
- Build without `HAZARD_PERF_CNT_EN`, repeat the first scenario -> identical control outputs, counters read 0.
